// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Memory-stage access controller. Converts the MEM-stage load/store control
// into a req/ack transaction on a multi-cycle data-memory bus, holds the
// pipeline (stall_o) while the transaction is outstanding, and presents the
// returned load data on ReadData_o for MEM_WB to capture in the DONE cycle.
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   MemRead_i         : MEM-stage load
//   MemWrite_i        : MEM-stage store (wins if both are set)
//   Addr_i            : byte address from the ALU
//   WriteData_i       : store data
//   ReadData_o        : registered load data
//   stall_o           : pipeline hold request (combinational)
//   misalign_o        : misaligned access flag (combinational)
//   timeout_o         : one-cycle pulse in DONE when the bus timed out
//   bus_req_o         : bus request (registered)
//   bus_we_o          : bus write enable, 1 = write (registered)
//   bus_addr_o        : word-aligned bus address (registered)
//   bus_wdata_o       : bus write data (registered)
//   bus_rdata_i       : bus read data, valid with bus_ack_i
//   bus_ack_i         : transaction complete
//
// Parameter
//   TIMEOUT           : maximum BUSY cycles to wait for bus_ack_i (>= 1)

module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             to_flag;

  logic acc;
  logic aligned;
  logic start;

  assign acc     = MemRead_i | MemWrite_i;
  assign aligned = (Addr_i[1:0] == 2'b00);
  assign start   = acc && aligned;

  // Qualified with rst_n so the pipeline sees no stall/flags while in reset,
  // whatever the MEM-stage inputs happen to be.
  assign stall_o    = rst_n && (((state == IDLE) && start) || (state == BUSY));
  assign misalign_o = rst_n && (state == IDLE) && acc && !aligned;
  assign timeout_o  = rst_n && (state == DONE) && to_flag;

  // NOTE: all state below is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      to_flag     <= 1'b0;
      ReadData_o  <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Misaligned accesses never reach the bus; ack is ignored here.
          if (start) begin
            bus_addr_o  <= {Addr_i[31:2], 2'b00};
            bus_wdata_o <= WriteData_i;
            bus_we_o    <= MemWrite_i;
            bus_req_o   <= 1'b1;
            cnt         <= '0;
            to_flag     <= 1'b0;
            state       <= BUSY;
          end
        end

        BUSY: begin
          // Bus-side registers are simply not written here, so they stay
          // stable for the whole transaction. Ack beats timeout.
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (!bus_we_o) ReadData_o <= bus_rdata_i;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            bus_req_o <= 1'b0;
            if (!bus_we_o) ReadData_o <= '0;
            to_flag <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          // Pipeline advances this cycle; the instruction is not relaunched.
          to_flag <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a small bus responder acks after a
// programmable number of BUSY cycles; each access pushes its expected
// outcome onto a scoreboard queue that is popped in the DONE cycle.

module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] Addr_i;
  logic [31:0] WriteData_i;
  logic [31:0] ReadData_o;
  logic        stall_o;
  logic        misalign_o;
  logic        timeout_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .Addr_i      (Addr_i),
    .WriteData_i (WriteData_i),
    .ReadData_o  (ReadData_o),
    .stall_o     (stall_o),
    .misalign_o  (misalign_o),
    .timeout_o   (timeout_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- bus responder ----------------
  int          ack_after = 0;   // ack in this BUSY cycle; 0 = never
  logic [31:0] resp_data = '0;
  logic        force_ack = 1'b0;
  int          busy_n    = 0;

  always @(negedge clk) begin
    if (force_ack) begin
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'h5555_AAAA;
    end else if (bus_req_o) begin
      busy_n = busy_n + 1;
      if (busy_n == ack_after) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = resp_data;
      end else begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'hDEAD_BEEF;
      end
    end else begin
      busy_n      = 0;
      bus_ack_i   = 1'b0;
      bus_rdata_i = 32'hDEAD_BEEF;
    end
  end

  // Idle-cycle gap before each rising edge of bus_req_o.
  int   low_run  = 100;
  int   last_gap = -1;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (bus_req_o && !prev_req) last_gap = low_run;
    low_run  = bus_req_o ? 0 : low_run + 1;
    prev_req = bus_req_o;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        to;
    int          stall;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata = '0;

  // Called just after a rising edge with the unit in IDLE. Returns just after
  // the DONE->IDLE edge with MEM inputs cleared.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_k,
                        input logic [31:0] rdata);
    exp_t e;
    exp_t g;
    int   cnt;
    e.we    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.to    = (ack_k == 0 || ack_k > TIMEOUT);
    e.stall = e.to ? TIMEOUT + 1 : ack_k + 1;
    if (!wr) model_rdata = e.to ? 32'h0 : rdata;
    e.rdata = model_rdata;
    sb.push_back(e);

    ack_after   = ack_k;
    resp_data   = rdata;
    MemRead_i   = rd;
    MemWrite_i  = wr;
    Addr_i      = addr;
    WriteData_i = wdata;

    cnt = 0;
    forever begin
      @(negedge clk);
      if (!stall_o) break;
      cnt++;
      if (cnt == 1) check("req_low_in_request_cycle", {31'b0, bus_req_o}, 32'h0);
      else begin
        check("req_held", {31'b0, bus_req_o}, 32'h1);
        check("bus_we_held", {31'b0, bus_we_o}, {31'b0, wr});
        check("bus_addr_held", bus_addr_o, addr);
        check("bus_wdata_held", bus_wdata_o, wdata);
      end
      if (cnt > 100) begin
        check("stall_bound_expired", 32'h1, 32'h0);
        break;
      end
    end

    g = sb.pop_front();
    check("stall_cycles", cnt, g.stall);
    check("done_rdata", ReadData_o, g.rdata);
    check("done_timeout", {31'b0, timeout_o}, {31'b0, g.to});
    check("done_req_low", {31'b0, bus_req_o}, 32'h0);
    check("done_we", {31'b0, bus_we_o}, {31'b0, g.we});

    @(posedge clk);
    #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    Addr_i      = '0;
    WriteData_i = '0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;

    // Reset state (with an access request present on the inputs).
    MemRead_i = 1'b1;
    #12;
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    check("rst_req", {31'b0, bus_req_o}, 32'h0);
    check("rst_rdata", ReadData_o, 32'h0);
    check("rst_addr", bus_addr_o, 32'h0);
    check("rst_timeout", {31'b0, timeout_o}, 32'h0);
    MemRead_i = 1'b0;
    rst_n = 1'b1;
    idle_cycles(2);

    // No access: no stall.
    @(negedge clk);
    check("noacc_stall", {31'b0, stall_o}, 32'h0);
    idle_cycles(1);

    // Read, ack in first BUSY cycle.
    access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hCAFE_0001);
    idle_cycles(1);

    // Write, ack after 4 BUSY cycles; ReadData_o unchanged.
    access(1'b0, 1'b1, 32'h24, 32'h1234_5678, 4, 32'h0BAD_0BAD);
    idle_cycles(1);

    // Read and write together: write wins.
    access(1'b1, 1'b1, 32'h40, 32'hA5A5_0F0F, 2, 32'h0BAD_0BAD);
    idle_cycles(1);

    // Misaligned read.
    MemRead_i = 1'b1;
    Addr_i    = 32'h102;
    @(negedge clk);
    check("mis_flag", {31'b0, misalign_o}, 32'h1);
    check("mis_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    check("mis_req", {31'b0, bus_req_o}, 32'h0);
    check("mis_rdata", ReadData_o, model_rdata);
    @(posedge clk);
    #1;
    MemRead_i = 1'b0;
    @(negedge clk);
    check("mis_flag_clear", {31'b0, misalign_o}, 32'h0);
    idle_cycles(1);

    // Reset in the 2nd BUSY cycle.
    ack_after = 5;
    MemRead_i = 1'b1;
    Addr_i    = 32'h200;
    @(negedge clk);              // IDLE request cycle
    @(negedge clk);              // BUSY 1
    @(negedge clk);              // BUSY 2
    check("pre_rst_req", {31'b0, bus_req_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", {31'b0, bus_req_o}, 32'h0);
    check("rst_mid_stall", {31'b0, stall_o}, 32'h0);
    check("rst_mid_rdata", ReadData_o, 32'h0);
    check("rst_mid_addr", bus_addr_o, 32'h0);
    MemRead_i = 1'b0;
    model_rdata = 32'h0;
    #2;
    rst_n = 1'b1;
    idle_cycles(2);
    check("post_rst_stall", {31'b0, stall_o}, 32'h0);

    // Next read completes normally.
    access(1'b1, 1'b0, 32'h204, 32'h0, 2, 32'h7777_1234);
    idle_cycles(1);

    // Timeout: read with no ack.
    access(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("timeout_pulse_end", {31'b0, timeout_o}, 32'h0);

    // Late ack in IDLE is ignored.
    force_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("late_ack_req", {31'b0, bus_req_o}, 32'h0);
    check("late_ack_stall", {31'b0, stall_o}, 32'h0);
    check("late_ack_rdata", ReadData_o, 32'h0);
    force_ack = 1'b0;
    idle_cycles(2);

    // Two back-to-back reads.
    access(1'b1, 1'b0, 32'h400, 32'h0, 1, 32'h1111_0001);
    access(1'b1, 1'b0, 32'h404, 32'h0, 1, 32'h2222_0002);
    check("b2b_gap", last_gap, 32'd2);
    check("sb_empty", sb.size(), 32'd0);

    idle_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
